fpu_result_collector: RTL and testbench
=======================================

Name: fpu_result_collector

Overview:
- Sits directly downstream of the HARDTHREAD-wide FP add/FMA lane array. Each lane delivers one result plus fflags per beat, and all lanes share one handshake.
- Gathers SOFTTHREAD/HARDTHREAD consecutive beats into one full SOFTTHREAD-wide writeback vector.
- OR-reduces the fflags of active lanes and holds the warp control fields.
- Presents the complete vector to vector writeback under valid/ready.

Parameters:
- EXPWIDTH, 8, exponent width of each result.
- PRECISION, 24, significand width including the hidden bit; LEN = EXPWIDTH+PRECISION.
- SOFTTHREAD, 8, threads per warp vector; must be an integer multiple of HARDTHREAD.
- HARDTHREAD, 4, physical FP lanes per beat.
- NUM_BEATS, SOFTTHREAD/HARDTHREAD, derived localparam.
- CNT_W, max(1,$clog2(NUM_BEATS)), derived localparam.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  a lane-array beat is present.
- in_ready_o  out  1  collector accepts the beat.
- in_result_i  in  HARDTHREAD*LEN  lane results; lane i occupies bits [i*LEN +: LEN].
- in_fflags_i  in  HARDTHREAD*5  lane fflags; lane i occupies bits [i*5 +: 5].
- in_reg_index_i  in  `REGIDX_WIDTH+`REGEXT_WIDTH  destination register.
- in_warp_id_i  in  `DEPTH_WARP  warp id.
- in_vec_mask_i  in  SOFTTHREAD  full-warp active mask, repeated on every beat.
- in_wvd_i  in  1  vector register write.
- in_wxd_i  in  1  scalar register write.
- out_valid_o  out  1  complete vector available.
- out_ready_i  in  1  writeback accepts the vector.
- out_result_o  out  SOFTTHREAD*LEN  thread t occupies bits [t*LEN +: LEN].
- out_fflags_o  out  5  OR of fflags over the active threads.
- out_reg_index_o, out_warp_id_o, out_vec_mask_o, out_wvd_o, out_wxd_o  out  same widths as the inputs  control fields of the vector.

Behaviour:
- Reset: all outputs and registers are 0: out_valid_o=0, beat counter cnt=0, result buffer 0, fflags accumulator 0, control fields 0. An asynchronous reset asserted mid-collection discards the partial vector.
- in_ready_o = !out_valid_o || out_ready_i. This is combinational from out_ready_i.
- A beat is accepted when acc = in_valid_i && in_ready_o.
- On acc with counter value b = cnt:
  - Buffer slot b*HARDTHREAD+i takes lane i, for all lanes. Masked-off lanes are written verbatim.
  - Lane i fflags contribute only if in_vec_mask_i[b*HARDTHREAD+i] is 1.
  - If b==0: accumulator = masked OR of this beat, and the control fields (reg_index, warp_id, vec_mask, wvd, wxd) are latched.
  - If b>0: accumulator |= masked OR of this beat. Control fields are not updated. Control inputs on later beats are ignored; a mismatch with beat 0 is a protocol violation with no checking.
  - If b==NUM_BEATS-1: cnt<=0 and out_valid_o<=1. Otherwise cnt<=b+1.
- Output handshake: when out_valid_o && out_ready_i and the same-cycle acc is not a last beat, out_valid_o<=0.
- Simultaneous drain and accept:
  - Beat 0 with NUM_BEATS>1: out_valid_o<=0; buffer slots are overwritten at the same edge, which is safe because the old vector has been consumed.
  - NUM_BEATS==1: out_valid_o stays 1 with the new vector.
- Held output: while out_valid_o && !out_ready_i, in_ready_o=0 and all outputs remain stable.
- Latency: out_valid_o rises 1 cycle after the last beat is accepted.
- Throughput: 1 beat/cycle; back-to-back vectors with no bubble when out_ready_i is held high.
- out_fflags_o is the accumulator register: bits are NV, DZ, OF, UF, NX from bit 4 down to bit 0.

Decomposition:
- Shared package/define file:
  - the existing `REGIDX_WIDTH, `REGEXT_WIDTH and `DEPTH_WARP macros;
  - FFLAG_NV/DZ/OF/UF/NX bit-index constants.
- Sub-module fflags_mask_or: a combinational masked OR of HARDTHREAD 5-bit flag vectors. It is reusable by the mul and cvt collectors.
- Counter, buffer and valid logic stay in the top module.

Test Plan:
- Reset, then idle: out_valid_o=0, in_ready_o=1, out_result_o=0, out_fflags_o=0.
- Normal 2-beat collection (SOFTTHREAD=8, HARDTHREAD=4):
  - Beats carry results 0x3F800000+t for t=0..7, mask 0xFF, and NX on lane 1 of beat 1.
  - Required: out_valid_o one cycle after beat 1; slot t = 0x3F800000+t; out_fflags_o=5'b00001.
- Masked fflags: mask 0x0F; beat 1 lanes carry NV=1.
  - Required: out_fflags_o=0 and out_vec_mask_o=0x0F.
- Backpressure:
  - out_ready_i=0 when the vector completes: in_ready_o=0 and outputs held for 5 cycles.
  - Raising out_ready_i alongside the next beat 0: drained, beat accepted, out_valid_o falls the next cycle.
- Streaming: 3 vectors over 6 consecutive beats with out_ready_i=1.
  - Required: out_valid_o pulses at cycles 2, 4, 6, each with correct warp_id 1, 2, 3.
- Reset mid-collection: assert rst_n=0 after beat 0, then send a fresh 2-beat vector.
  - Required: the output contains only the new data, with no stale slots or flags.

Source files
------------

// File: rtl/fpu_result_collector_pkg.sv
// Shared definitions for the FP result collectors (add/FMA, mul, cvt).
// Supplies the destination-register and warp-id widths and the fflags bit
// layout. Ports: none (package only).

`ifndef REGIDX_WIDTH
`define REGIDX_WIDTH 5
`endif
`ifndef REGEXT_WIDTH
`define REGEXT_WIDTH 3
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

package fpu_result_collector_pkg;

  localparam int REGIDX_W = `REGIDX_WIDTH;
  localparam int REGEXT_W = `REGEXT_WIDTH;
  localparam int REG_W    = REGIDX_W + REGEXT_W;
  localparam int WARP_W   = `DEPTH_WARP;
  localparam int FFLAG_W  = 5;

  // Bit positions inside a 5-bit fflags vector.
  typedef enum int unsigned {
    FFLAG_NX = 0,
    FFLAG_UF = 1,
    FFLAG_OF = 2,
    FFLAG_DZ = 3,
    FFLAG_NV = 4
  } fflag_idx_e;

  // Counter width that stays at least one bit for a single-beat warp.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_result_collector_mask_or.sv
// fflags_mask_or: combinational OR of HARDTHREAD 5-bit fflags vectors,
// where each lane contributes only when its mask bit is set.
// Ports:
//   fflags_i  lane flags, lane i at [i*5 +: 5]
//   mask_i    per-lane active mask
//   flags_o   OR of the active lanes' flags

module fflags_mask_or
  import fpu_result_collector_pkg::*;
#(
  parameter int HARDTHREAD = 4
) (
  input  logic [HARDTHREAD*FFLAG_W-1:0] fflags_i,
  input  logic [HARDTHREAD-1:0]         mask_i,
  output logic [FFLAG_W-1:0]            flags_o
);

  always_comb begin
    flags_o = '0;
    for (int i = 0; i < HARDTHREAD; i++) begin
      if (mask_i[i]) begin
        flags_o = flags_o | fflags_i[i*FFLAG_W +: FFLAG_W];
      end
    end
  end

endmodule

// File: rtl/fpu_result_collector.sv
// fpu_result_collector: gathers SOFTTHREAD/HARDTHREAD consecutive beats from
// the HARDTHREAD-wide FP add/FMA lane array into one SOFTTHREAD-wide
// writeback vector, OR-reducing the fflags of active threads and holding the
// warp control fields captured on the first beat.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid_i / in_ready_o          lane-array beat handshake
//   in_result_i, in_fflags_i         per-lane results and flags
//   in_reg_index_i .. in_wxd_i       warp control fields (used on beat 0)
//   out_valid_o / out_ready_i        writeback vector handshake
//   out_result_o, out_fflags_o       full vector and accumulated flags
//   out_reg_index_o .. out_wxd_o     control fields of the held vector

module fpu_result_collector
  import fpu_result_collector_pkg::*;
#(
  parameter int EXPWIDTH   = 8,
  parameter int PRECISION  = 24,
  parameter int SOFTTHREAD = 8,
  parameter int HARDTHREAD = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [HARDTHREAD*(EXPWIDTH+PRECISION)-1:0] in_result_i,
  input  logic [HARDTHREAD*FFLAG_W-1:0]         in_fflags_i,
  input  logic [REG_W-1:0]                      in_reg_index_i,
  input  logic [WARP_W-1:0]                     in_warp_id_i,
  input  logic [SOFTTHREAD-1:0]                 in_vec_mask_i,
  input  logic                                  in_wvd_i,
  input  logic                                  in_wxd_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [SOFTTHREAD*(EXPWIDTH+PRECISION)-1:0] out_result_o,
  output logic [FFLAG_W-1:0]                    out_fflags_o,
  output logic [REG_W-1:0]                      out_reg_index_o,
  output logic [WARP_W-1:0]                     out_warp_id_o,
  output logic [SOFTTHREAD-1:0]                 out_vec_mask_o,
  output logic                                  out_wvd_o,
  output logic                                  out_wxd_o
);

  localparam int LEN       = EXPWIDTH + PRECISION;
  localparam int NUM_BEATS = SOFTTHREAD / HARDTHREAD;
  localparam int CNT_W     = cnt_width(NUM_BEATS);

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       vld_q, vld_d;
  logic [SOFTTHREAD*LEN-1:0]  res_q, res_d;
  logic [FFLAG_W-1:0]         ffl_q, ffl_d;
  logic [REG_W-1:0]           reg_index_q, reg_index_d;
  logic [WARP_W-1:0]          warp_id_q, warp_id_d;
  logic [SOFTTHREAD-1:0]      vec_mask_q, vec_mask_d;
  logic                       wvd_q, wvd_d;
  logic                       wxd_q, wxd_d;

  logic                       acc;
  logic                       last_beat;
  int                         beat_base;
  logic [HARDTHREAD-1:0]      beat_mask;
  logic [FFLAG_W-1:0]         beat_flags;

  // A drained output frees the buffer in the same cycle, so a new beat may
  // land on the edge that consumes the old vector.
  assign in_ready_o = !vld_q || out_ready_i;
  assign acc        = in_valid_i && in_ready_o;
  assign last_beat  = (cnt_q == CNT_W'(NUM_BEATS - 1));

  always_comb begin
    beat_base = int'(cnt_q) * HARDTHREAD;
    beat_mask = in_vec_mask_i[beat_base +: HARDTHREAD];
  end

  fflags_mask_or #(
    .HARDTHREAD (HARDTHREAD)
  ) u_mask_or (
    .fflags_i (in_fflags_i),
    .mask_i   (beat_mask),
    .flags_o  (beat_flags)
  );

  always_comb begin
    cnt_d       = cnt_q;
    vld_d       = vld_q;
    res_d       = res_q;
    ffl_d       = ffl_q;
    reg_index_d = reg_index_q;
    warp_id_d   = warp_id_q;
    vec_mask_d  = vec_mask_q;
    wvd_d       = wvd_q;
    wxd_d       = wxd_q;

    if (vld_q && out_ready_i) begin
      vld_d = 1'b0;
    end

    if (acc) begin
      // Masked-off lanes are stored verbatim; only their flags are dropped.
      res_d[beat_base*LEN +: HARDTHREAD*LEN] = in_result_i;
      if (cnt_q == '0) begin
        ffl_d       = beat_flags;
        reg_index_d = in_reg_index_i;
        warp_id_d   = in_warp_id_i;
        vec_mask_d  = in_vec_mask_i;
        wvd_d       = in_wvd_i;
        wxd_d       = in_wxd_i;
      end else begin
        ffl_d = ffl_q | beat_flags;
      end
      // A last beat overrides any same-cycle drain, keeping valid high.
      if (last_beat) begin
        cnt_d = '0;
        vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Collection stage register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      vld_q       <= 1'b0;
      res_q       <= '0;
      ffl_q       <= '0;
      reg_index_q <= '0;
      warp_id_q   <= '0;
      vec_mask_q  <= '0;
      wvd_q       <= 1'b0;
      wxd_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      vld_q       <= vld_d;
      res_q       <= res_d;
      ffl_q       <= ffl_d;
      reg_index_q <= reg_index_d;
      warp_id_q   <= warp_id_d;
      vec_mask_q  <= vec_mask_d;
      wvd_q       <= wvd_d;
      wxd_q       <= wxd_d;
    end
  end

  assign out_valid_o     = vld_q;
  assign out_result_o    = res_q;
  assign out_fflags_o    = ffl_q;
  assign out_reg_index_o = reg_index_q;
  assign out_warp_id_o   = warp_id_q;
  assign out_vec_mask_o  = vec_mask_q;
  assign out_wvd_o       = wvd_q;
  assign out_wxd_o       = wxd_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Scoreboard bench for fpu_result_collector (SOFTTHREAD=8, HARDTHREAD=4).
// The driver pushes the expected warp vector when its last beat is accepted;
// a monitor pops and compares on every output handshake.

module tb_fpu_result_collector;
  import fpu_result_collector_pkg::*;

  localparam int LEN = 32;
  localparam int ST  = 8;
  localparam int HT  = 4;
  localparam int NB  = ST / HT;
  localparam int CW  = ST * LEN;

  logic              clk;
  logic              rst_n;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [HT*LEN-1:0] in_result_i;
  logic [HT*5-1:0]   in_fflags_i;
  logic [REG_W-1:0]  in_reg_index_i;
  logic [WARP_W-1:0] in_warp_id_i;
  logic [ST-1:0]     in_vec_mask_i;
  logic              in_wvd_i;
  logic              in_wxd_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [CW-1:0]     out_result_o;
  logic [4:0]        out_fflags_o;
  logic [REG_W-1:0]  out_reg_index_o;
  logic [WARP_W-1:0] out_warp_id_o;
  logic [ST-1:0]     out_vec_mask_o;
  logic              out_wvd_o;
  logic              out_wxd_o;

  fpu_result_collector #(
    .EXPWIDTH   (8),
    .PRECISION  (24),
    .SOFTTHREAD (ST),
    .HARDTHREAD (HT)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid_i),
    .in_ready_o      (in_ready_o),
    .in_result_i     (in_result_i),
    .in_fflags_i     (in_fflags_i),
    .in_reg_index_i  (in_reg_index_i),
    .in_warp_id_i    (in_warp_id_i),
    .in_vec_mask_i   (in_vec_mask_i),
    .in_wvd_i        (in_wvd_i),
    .in_wxd_i        (in_wxd_i),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .out_result_o    (out_result_o),
    .out_fflags_o    (out_fflags_o),
    .out_reg_index_o (out_reg_index_o),
    .out_warp_id_o   (out_warp_id_o),
    .out_vec_mask_o  (out_vec_mask_o),
    .out_wvd_o       (out_wvd_o),
    .out_wxd_o       (out_wxd_o)
  );

  typedef struct {
    logic [CW-1:0]     res;
    logic [4:0]        ff;
    logic [REG_W-1:0]  ri;
    logic [WARP_W-1:0] wid;
    logic [ST-1:0]     mask;
    logic              wvd;
    logic              wxd;
  } exp_t;

  int   total;
  int   bad;
  int   cyc;
  exp_t sbq[$];
  int   vlog[$];
  bit   rand_rdy;
  bit   chk_drop;
  bit   mon_log;

  // Warp vector currently being sent, one entry per thread.
  logic [LEN-1:0]    v_res[ST];
  logic [4:0]        v_flg[ST];
  logic [ST-1:0]     v_mask;
  logic [REG_W-1:0]  v_ri;
  logic [WARP_W-1:0] v_wid;
  logic              v_wvd;
  logic              v_wxd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: the vector is the thread results in order; flags are the OR
  // of every active thread's flags; control comes from the warp itself.
  function automatic exp_t build_exp();
    exp_t e;
    e.res = '0;
    e.ff  = '0;
    for (int t = 0; t < ST; t++) begin
      e.res[t*LEN +: LEN] = v_res[t];
      if (v_mask[t]) e.ff = e.ff | v_flg[t];
    end
    e.ri   = v_ri;
    e.wid  = v_wid;
    e.mask = v_mask;
    e.wvd  = v_wvd;
    e.wxd  = v_wxd;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic rand_vec();
    for (int t = 0; t < ST; t++) begin
      v_res[t] = $urandom;
      v_flg[t] = 5'($urandom);
    end
    v_mask = ST'($urandom);
    v_ri   = REG_W'($urandom);
    v_wid  = WARP_W'($urandom);
    v_wvd  = 1'($urandom);
    v_wxd  = 1'($urandom);
  endtask

  task automatic send_beat(input int b);
    int n;
    bit ok;
    in_valid_i = 1'b1;
    for (int i = 0; i < HT; i++) begin
      in_result_i[i*LEN +: LEN] = v_res[b*HT+i];
      in_fflags_i[i*5 +: 5]     = v_flg[b*HT+i];
    end
    in_vec_mask_i = v_mask;
    if (b == 0) begin
      in_reg_index_i = v_ri;
      in_warp_id_i   = v_wid;
      in_wvd_i       = v_wvd;
      in_wxd_i       = v_wxd;
    end else begin
      // Later beats carry unrelated control values that must be ignored.
      in_reg_index_i = REG_W'($urandom);
      in_warp_id_i   = WARP_W'($urandom);
      in_wvd_i       = 1'($urandom);
      in_wxd_i       = 1'($urandom);
    end
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready_o) begin
        ok = 1'b1;
        if (b == NB - 1) sbq.push_back(build_exp());
      end
      tick();
      n++;
    end
    in_valid_i = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: beat %0d not accepted after %0d cycles", b, n);
    end else if (b == NB - 1) begin
      chk("latency_valid", CW'(out_valid_o), CW'(1'b1));
    end else if (b == 0 && chk_drop) begin
      chk("drain_valid_drop", CW'(out_valid_o), CW'(1'b0));
      chk_drop = 1'b0;
    end
  endtask

  task automatic send_vector();
    for (int b = 0; b < NB; b++) send_beat(b);
  endtask

  // Monitor: every output handshake consumes one scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid_o) begin
        if (mon_log) vlog.push_back(cyc);
        if (out_ready_i) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_vector: actual=valid required=none_pending");
          end else begin
            e = sbq.pop_front();
            chk("sb_result",    out_result_o,            e.res);
            chk("sb_fflags",    CW'(out_fflags_o),       CW'(e.ff));
            chk("sb_reg_index", CW'(out_reg_index_o),    CW'(e.ri));
            chk("sb_warp_id",   CW'(out_warp_id_o),      CW'(e.wid));
            chk("sb_vec_mask",  CW'(out_vec_mask_o),     CW'(e.mask));
            chk("sb_wvd",       CW'(out_wvd_o),          CW'(e.wvd));
            chk("sb_wxd",       CW'(out_wxd_o),          CW'(e.wxd));
          end
        end
      end
    end
  end

  initial begin
    #300000;
    bad++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    exp_t eh;
    int   t0;
    total          = 0;
    bad            = 0;
    rand_rdy       = 1'b0;
    chk_drop       = 1'b0;
    mon_log        = 1'b0;
    rst_n          = 1'b0;
    in_valid_i     = 1'b0;
    in_result_i    = '0;
    in_fflags_i    = '0;
    in_reg_index_i = '0;
    in_warp_id_i   = '0;
    in_vec_mask_i  = '0;
    in_wvd_i       = 1'b0;
    in_wxd_i       = 1'b0;
    out_ready_i    = 1'b0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid",  CW'(out_valid_o),  CW'(1'b0));
    chk("rst_result", out_result_o,      CW'(0));
    chk("rst_fflags", CW'(out_fflags_o), CW'(0));
    chk("rst_warp",   CW'(out_warp_id_o), CW'(0));
    rst_n       = 1'b1;
    out_ready_i = 1'b1;
    tick();
    chk("idle_valid",  CW'(out_valid_o), CW'(1'b0));
    chk("idle_ready",  CW'(in_ready_o),  CW'(1'b1));
    chk("idle_result", out_result_o,     CW'(0));
    chk("idle_fflags", CW'(out_fflags_o), CW'(0));

    // Normal 2-beat collection, NX on lane 1 of beat 1 (thread 5)
    for (int t = 0; t < ST; t++) begin
      v_res[t] = 32'h3F80_0000 + 32'(t);
      v_flg[t] = 5'b0;
    end
    v_flg[5] = 5'b00001;
    v_mask   = 8'hFF;
    v_ri     = REG_W'(9);
    v_wid    = WARP_W'(1);
    v_wvd    = 1'b1;
    v_wxd    = 1'b0;
    send_vector();
    chk("normal_fflags", CW'(out_fflags_o), CW'(5'b00001));
    chk("normal_slot3",  CW'(out_result_o[3*LEN +: LEN]), CW'(32'h3F80_0003));
    chk("normal_slot7",  CW'(out_result_o[7*LEN +: LEN]), CW'(32'h3F80_0007));
    tick();

    // Masked flags: inactive upper threads raise NV
    rand_vec();
    for (int t = 0; t < ST; t++) v_flg[t] = (t >= HT) ? 5'b10000 : 5'b00000;
    v_mask = 8'h0F;
    send_vector();
    chk("masked_fflags", CW'(out_fflags_o),   CW'(0));
    chk("masked_vmask",  CW'(out_vec_mask_o), CW'(8'h0F));
    tick();

    // Backpressure: hold for 5 cycles with a beat waiting
    out_ready_i = 1'b0;
    rand_vec();
    send_vector();
    eh = build_exp();
    in_valid_i  = 1'b1;
    in_result_i = '1;
    in_fflags_i = '1;
    repeat (5) begin
      tick();
      chk("hold_in_ready", CW'(in_ready_o),   CW'(1'b0));
      chk("hold_valid",    CW'(out_valid_o),  CW'(1'b1));
      chk("hold_result",   out_result_o,      eh.res);
      chk("hold_fflags",   CW'(out_fflags_o), CW'(eh.ff));
      chk("hold_warp",     CW'(out_warp_id_o), CW'(eh.wid));
    end
    out_ready_i = 1'b1;
    rand_vec();
    chk_drop = 1'b1;
    send_vector();
    tick();
    tick();

    // Streaming: 3 vectors over 6 back-to-back beats
    vlog.delete();
    mon_log = 1'b1;
    t0      = cyc;
    for (int w = 1; w <= 3; w++) begin
      rand_vec();
      v_wid = WARP_W'(w);
      send_vector();
    end
    tick();
    mon_log = 1'b0;
    chk("stream_pulses", CW'(vlog.size()), CW'(3));
    for (int k = 0; k < 3; k++) begin
      chk("stream_cycle", CW'((k < vlog.size()) ? vlog[k] - t0 : -1), CW'(2 + 2*k));
    end
    tick();

    // Reset mid-collection
    rand_vec();
    for (int t = 0; t < ST; t++) v_flg[t] = 5'b10000;
    v_mask = 8'hFF;
    send_beat(0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",  CW'(out_valid_o),  CW'(1'b0));
    chk("midrst_result", out_result_o,      CW'(0));
    chk("midrst_fflags", CW'(out_fflags_o), CW'(0));
    tick();
    rst_n = 1'b1;
    tick();
    rand_vec();
    for (int t = 0; t < ST; t++) v_flg[t] = 5'b0;
    v_flg[2] = 5'b00010;
    v_mask   = 8'hFF;
    send_vector();
    chk("midrst_new_fflags", CW'(out_fflags_o), CW'(5'b00010));
    tick();

    // Randomized traffic with random backpressure and idle gaps
    rand_rdy = 1'b1;
    repeat (40) begin
      rand_vec();
      send_vector();
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy    = 1'b0;
    out_ready_i = 1'b1;
    repeat (4) tick();
    chk("sb_drained", CW'(sbq.size()), CW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
